iob_eth_tx_bd_sched: RTL

Hardware scheduler that walks the Ethernet transmit buffer-descriptor (BD) table and sequences the TX datapath without CPU involvement per frame. When transmission is enabled, it polls the current TX BD and, on finding READY set, fetches the buffer pointer and launches the transmitter. On completion it writes the status back, raises interrupts and advances to the next BD, honouring the WRAP bit. It sits between the BD RAM port of the core's register/BD space and the TX MAC datapath.

---
 rtl/iob_eth_tx_bd_sched.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/iob_eth_tx_bd_sched.sv
// TX buffer-descriptor scheduler: polls the TX BD ring, launches frames on the
// MAC datapath, writes completion status back and raises per-frame interrupts.
module iob_eth_tx_bd_sched #(
    parameter int BD_NUM_LOG2 = 7,
    parameter int TX_BD_NUM   = 64,
    parameter int DATA_W      = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   tx_en_i,
    output logic                   bd_en_o,
    output logic                   bd_we_o,
    output logic [BD_NUM_LOG2:0]   bd_addr_o,
    output logic [DATA_W-1:0]      bd_wdata_o,
    input  logic [DATA_W-1:0]      bd_rdata_i,
    output logic                   tx_start_o,
    output logic [DATA_W-1:0]      tx_ptr_o,
    output logic [15:0]            tx_len_o,
    output logic                   tx_crc_en_o,
    output logic                   tx_pad_en_o,
    input  logic                   tx_done_i,
    input  logic                   tx_underrun_i,
    output logic                   txb_irq_o,
    output logic                   txe_irq_o,
    output logic                   busy_o,
    output logic [BD_NUM_LOG2-1:0] cur_idx_o
);

    localparam int BIT_RD  = 15;
    localparam int BIT_IRQ = 14;
    localparam int BIT_WR  = 13;
    localparam int BIT_PAD = 12;
    localparam int BIT_CRC = 11;
    localparam int BIT_UR  = 8;

    localparam logic [BD_NUM_LOG2-1:0] LAST_IDX = BD_NUM_LOG2'(TX_BD_NUM - 1);
    localparam logic [BD_NUM_LOG2-1:0] ONE_IDX  = BD_NUM_LOG2'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CTRL,
        S_WAIT_CTRL,
        S_RD_PTR,
        S_WAIT_PTR,
        S_START,
        S_BUSY,
        S_WB
    } state_t;

    state_t                 state_q, state_d;
    logic [BD_NUM_LOG2-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]      ctrl_q, ctrl_d;
    logic                   bd_en_q, bd_en_d;
    logic                   bd_we_q, bd_we_d;
    logic [BD_NUM_LOG2:0]   bd_addr_q, bd_addr_d;
    logic [DATA_W-1:0]      bd_wdata_q, bd_wdata_d;
    logic                   tx_start_q, tx_start_d;
    logic [DATA_W-1:0]      tx_ptr_q, tx_ptr_d;
    logic [15:0]            tx_len_q, tx_len_d;
    logic                   tx_crc_en_q, tx_crc_en_d;
    logic                   tx_pad_en_q, tx_pad_en_d;
    logic                   txb_irq_q, txb_irq_d;
    logic                   txe_irq_q, txe_irq_d;
    logic                   busy_q, busy_d;

    // Status word handed back to software: READY released, UR reflects this frame.
    function automatic logic [DATA_W-1:0] wb_word(input logic [DATA_W-1:0] word,
                                                  input logic              ur);
        logic [DATA_W-1:0] res;
        res         = word;
        res[BIT_RD] = 1'b0;
        res[BIT_UR] = ur;
        return res;
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ctrl_d      = ctrl_q;
        tx_ptr_d    = tx_ptr_q;
        tx_len_d    = tx_len_q;
        tx_crc_en_d = tx_crc_en_q;
        tx_pad_en_d = tx_pad_en_q;
        bd_wdata_d  = '0;
        txb_irq_d   = 1'b0;
        txe_irq_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (tx_en_i) begin
                    state_d = S_RD_CTRL;
                end
            end
            S_RD_CTRL: begin
                state_d = tx_en_i ? S_WAIT_CTRL : S_IDLE;
            end
            S_WAIT_CTRL: begin
                if (!tx_en_i || !bd_rdata_i[BIT_RD]) begin
                    state_d = S_IDLE;
                end else begin
                    ctrl_d = bd_rdata_i;
                    if (bd_rdata_i[31:16] != 16'd0) begin
                        state_d = S_RD_PTR;
                    end else begin
                        // Zero-length frame is never launched; report it as an error.
                        state_d    = S_WB;
                        bd_wdata_d = wb_word(bd_rdata_i, 1'b0);
                        txe_irq_d  = bd_rdata_i[BIT_IRQ];
                    end
                end
            end
            S_RD_PTR: begin
                state_d = tx_en_i ? S_WAIT_PTR : S_IDLE;
            end
            S_WAIT_PTR: begin
                if (!tx_en_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d     = S_START;
                    tx_ptr_d    = bd_rdata_i;
                    tx_len_d    = ctrl_q[31:16];
                    tx_crc_en_d = ctrl_q[BIT_CRC];
                    tx_pad_en_d = ctrl_q[BIT_PAD];
                end
            end
            S_START: begin
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (tx_done_i) begin
                    state_d    = S_WB;
                    bd_wdata_d = wb_word(ctrl_q, tx_underrun_i);
                    txe_irq_d  = ctrl_q[BIT_IRQ] && tx_underrun_i;
                    txb_irq_d  = ctrl_q[BIT_IRQ] && !tx_underrun_i;
                end
            end
            S_WB: begin
                if (ctrl_q[BIT_WR] || (idx_q == LAST_IDX)) begin
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + ONE_IDX;
                end
                state_d = tx_en_i ? S_RD_CTRL : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Port strobes are decoded from the next state so they line up with it.
        bd_en_d    = (state_d == S_RD_CTRL) || (state_d == S_RD_PTR) || (state_d == S_WB);
        bd_we_d    = (state_d == S_WB);
        tx_start_d = (state_d == S_START);
        busy_d     = (state_d == S_START) || (state_d == S_BUSY) || (state_d == S_WB);

        if (state_d == S_RD_PTR) begin
            bd_addr_d = {idx_d, 1'b1};
        end else if ((state_d == S_RD_CTRL) || (state_d == S_WB)) begin
            bd_addr_d = {idx_d, 1'b0};
        end else begin
            bd_addr_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            ctrl_q      <= '0;
            bd_en_q     <= 1'b0;
            bd_we_q     <= 1'b0;
            bd_addr_q   <= '0;
            bd_wdata_q  <= '0;
            tx_start_q  <= 1'b0;
            tx_ptr_q    <= '0;
            tx_len_q    <= '0;
            tx_crc_en_q <= 1'b0;
            tx_pad_en_q <= 1'b0;
            txb_irq_q   <= 1'b0;
            txe_irq_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ctrl_q      <= ctrl_d;
            bd_en_q     <= bd_en_d;
            bd_we_q     <= bd_we_d;
            bd_addr_q   <= bd_addr_d;
            bd_wdata_q  <= bd_wdata_d;
            tx_start_q  <= tx_start_d;
            tx_ptr_q    <= tx_ptr_d;
            tx_len_q    <= tx_len_d;
            tx_crc_en_q <= tx_crc_en_d;
            tx_pad_en_q <= tx_pad_en_d;
            txb_irq_q   <= txb_irq_d;
            txe_irq_q   <= txe_irq_d;
            busy_q      <= busy_d;
        end
    end

    assign bd_en_o     = bd_en_q;
    assign bd_we_o     = bd_we_q;
    assign bd_addr_o   = bd_addr_q;
    assign bd_wdata_o  = bd_wdata_q;
    assign tx_start_o  = tx_start_q;
    assign tx_ptr_o    = tx_ptr_q;
    assign tx_len_o    = tx_len_q;
    assign tx_crc_en_o = tx_crc_en_q;
    assign tx_pad_en_o = tx_pad_en_q;
    assign txb_irq_o   = txb_irq_q;
    assign txe_irq_o   = txe_irq_q;
    assign busy_o      = busy_q;
    assign cur_idx_o   = idx_q;

endmodule
